// File: rtl/vex_ibus_responder.sv
// iBus responder: in-order pending FIFO, answers no earlier than 1 cycle after accept.
// Backpressure: cmd_ready drops when full or randomly stalled; FAIR caps both stalls at MAX_STALL.
module vex_ibus_responder #(
  parameter int DEPTH     = 4,
  parameter int MAX_STALL = 3,
  parameter int FAIR      = 1
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       cmd_valid,
  input  logic [31:0]                cmd_pc,
  output logic                       cmd_ready,
  output logic                       rsp_valid,
  output logic [31:0]                rsp_inst,
  output logic [31:0]                rsp_pc,
  input  logic                       rand_cmd_ready,
  input  logic                       rand_rsp_valid,
  input  logic [31:0]                rand_inst,
  output logic [$clog2(DEPTH+1)-1:0] pending,
  output logic                       protocol_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(MAX_STALL + 1);

  logic [31:0]   fifoMem [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [SW-1:0] cmdStall;
  logic [SW-1:0] rspStall;
  logic          stalledQ;
  logic [31:0]   pcQ;

  logic full;
  logic empty;
  logic cmdForce;
  logic rspForce;
  logic push;
  logic pop;

  assign full     = (pending == CW'(DEPTH));
  assign empty    = (pending == '0);
  assign cmdForce = (FAIR != 0) && (cmdStall == SW'(MAX_STALL));
  assign rspForce = (FAIR != 0) && (rspStall == SW'(MAX_STALL));

  assign cmd_ready = !full && (rand_cmd_ready || cmdForce);
  assign rsp_valid = !empty && (rand_rsp_valid || rspForce);
  assign rsp_inst  = rand_inst;
  assign rsp_pc    = fifoMem[rdPtr];

  assign push = cmd_valid && cmd_ready;
  assign pop  = rsp_valid;

  // Storage carries no reset; only entries below pending are ever observed.
  always_ff @(posedge clock) begin
    if (push) begin
      fifoMem[wrPtr] <= cmd_pc;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wrPtr        <= '0;
      rdPtr        <= '0;
      pending      <= '0;
      cmdStall     <= '0;
      rspStall     <= '0;
      stalledQ     <= 1'b0;
      pcQ          <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PW'(1);
      end

      case ({push, pop})
        2'b10:   pending <= pending + CW'(1);
        2'b01:   pending <= pending - CW'(1);
        default: pending <= pending;
      endcase

      if (cmd_valid && !cmd_ready) begin
        if (cmdStall != SW'(MAX_STALL)) begin
          cmdStall <= cmdStall + SW'(1);
        end
      end else begin
        cmdStall <= '0;
      end

      if (!empty && !rsp_valid) begin
        if (rspStall != SW'(MAX_STALL)) begin
          rspStall <= rspStall + SW'(1);
        end
      end else begin
        rspStall <= '0;
      end

      // A stalled command must stay valid with the same pc until accepted.
      stalledQ <= cmd_valid && !cmd_ready;
      pcQ      <= cmd_pc;
      if (stalledQ && (!cmd_valid || (cmd_pc != pcQ))) begin
        protocol_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vex_ibus_responder.sv
// Directed bench for vex_ibus_responder: one fair and one unfair instance share stimulus.
module tb_vex_ibus_responder;

  logic        clock;
  logic        resetn;
  logic        cmdValid;
  logic [31:0] cmdPc;
  logic        randCmdReady;
  logic        randRspValid;
  logic [31:0] randInst;

  logic        fReady, fRspV, fErr;
  logic [31:0] fInst, fRspPc;
  logic [2:0]  fPend;
  logic        nReady, nRspV, nErr;
  logic [31:0] nInst, nRspPc;
  logic [2:0]  nPend;

  int nChecks = 0;
  int nErrors = 0;

  vex_ibus_responder #(.DEPTH(4), .MAX_STALL(3), .FAIR(1)) dutFair (
    .clock(clock), .resetn(resetn),
    .cmd_valid(cmdValid), .cmd_pc(cmdPc), .cmd_ready(fReady),
    .rsp_valid(fRspV), .rsp_inst(fInst), .rsp_pc(fRspPc),
    .rand_cmd_ready(randCmdReady), .rand_rsp_valid(randRspValid), .rand_inst(randInst),
    .pending(fPend), .protocol_err(fErr)
  );

  vex_ibus_responder #(.DEPTH(4), .MAX_STALL(3), .FAIR(0)) dutNoFair (
    .clock(clock), .resetn(resetn),
    .cmd_valid(cmdValid), .cmd_pc(cmdPc), .cmd_ready(nReady),
    .rsp_valid(nRspV), .rsp_inst(nInst), .rsp_pc(nRspPc),
    .rand_cmd_ready(randCmdReady), .rand_rsp_valid(randRspValid), .rand_inst(randInst),
    .pending(nPend), .protocol_err(nErr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic doReset();
    resetn       = 1'b0;
    cmdValid     = 1'b0;
    cmdPc        = 32'h0;
    randCmdReady = 1'b0;
    randRspValid = 1'b0;
    randInst     = 32'h0;
    step();
    step();
    resetn = 1'b1;
  endtask

  // Unfair instance: rsp pc per cycle while draining with interleaved pushes.
  logic [31:0] drainPc [5];
  logic [2:0]  drainPend [5];

  initial begin
    drainPc[0] = 32'h4;  drainPend[0] = 3'd3;
    drainPc[1] = 32'h8;  drainPend[1] = 3'd3;
    drainPc[2] = 32'hC;  drainPend[2] = 3'd2;
    drainPc[3] = 32'h10; drainPend[3] = 3'd1;
    drainPc[4] = 32'h14; drainPend[4] = 3'd0;

    // Reset and idle
    resetn       = 1'b0;
    cmdValid     = 1'b0;
    cmdPc        = 32'h0;
    randCmdReady = 1'b1;
    randRspValid = 1'b1;
    randInst     = 32'h0;
    step();
    step();
    chk("rst_pending", fPend, 0);
    chk("rst_rsp_valid", fRspV, 0);
    chk("rst_protocol_err", fErr, 0);
    chk("rst_cmd_ready_hi", fReady, 1);
    randCmdReady = 1'b0;
    settle();
    chk("rst_cmd_ready_lo", fReady, 0);
    chk("rst_nofair_ready_lo", nReady, 0);
    randRspValid = 1'b0;
    step();
    resetn = 1'b1;

    // Single fetch
    cmdValid     = 1'b1;
    cmdPc        = 32'h8000_0000;
    randCmdReady = 1'b1;
    settle();
    chk("single_ready", fReady, 1);
    chk("single_no_early_rsp", fRspV, 0);
    step();
    cmdValid     = 1'b0;
    randRspValid = 1'b1;
    randInst     = 32'h0000_0013;
    settle();
    chk("single_pending1", fPend, 1);
    chk("single_rsp_valid", fRspV, 1);
    chk("single_rsp_pc", fRspPc, 32'h8000_0000);
    chk("single_rsp_inst", fInst, 32'h0000_0013);
    step();
    chk("single_pending0", fPend, 0);
    chk("single_rsp_done", fRspV, 0);

    // Fill and wrap, unbounded stalls
    doReset();
    randCmdReady = 1'b1;
    cmdValid     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmdPc = 32'(4 * i);
      settle();
      chk("fill_ready", nReady, 1);
      step();
    end
    cmdPc = 32'h10;
    settle();
    chk("fill_full_pending", nPend, 4);
    chk("fill_full_ready", nReady, 0);
    chk("fill_no_rsp", nRspV, 0);
    step();
    chk("fill_still_blocked", nReady, 0);
    randRspValid = 1'b1;
    settle();
    chk("drain_rsp0_valid", nRspV, 1);
    chk("drain_rsp0_pc", nRspPc, 32'h0);
    chk("drain_full_ready", nReady, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      if (i == 1) cmdPc = 32'h14;
      if (i == 2) cmdValid = 1'b0;
      settle();
      chk("drain_rsp_valid", nRspV, 1);
      chk("drain_rsp_pc", nRspPc, drainPc[i]);
      step();
      chk("drain_pending", nPend, drainPend[i]);
    end
    chk("drain_empty_rsp", nRspV, 0);
    chk("drain_no_err", nErr, 0);

    // Fairness on both channels
    doReset();
    cmdValid = 1'b1;
    cmdPc    = 32'h200;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("fair_cmd_stalled", fReady, 0);
      step();
    end
    settle();
    chk("fair_cmd_forced", fReady, 1);
    chk("nofair_cmd_stalled", nReady, 0);
    step();
    cmdValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("fair_rsp_stalled", fRspV, 0);
      step();
    end
    settle();
    chk("fair_rsp_forced", fRspV, 1);
    chk("fair_rsp_pc", fRspPc, 32'h200);
    step();
    chk("fair_pending0", fPend, 0);
    chk("fair_no_err", fErr, 0);

    // Simultaneous push and pop
    doReset();
    randCmdReady = 1'b1;
    cmdValid     = 1'b1;
    cmdPc        = 32'h300;
    step();
    cmdPc = 32'h304;
    step();
    cmdPc        = 32'h308;
    randRspValid = 1'b1;
    settle();
    chk("pp_pending_before", fPend, 2);
    chk("pp_rsp_pc_before", fRspPc, 32'h300);
    chk("pp_both_fire", {31'b0, fReady && fRspV}, 1);
    step();
    cmdValid = 1'b0;
    settle();
    chk("pp_pending_after", fPend, 2);
    chk("pp_rsp_pc_after", fRspPc, 32'h304);
    step();
    chk("pp_rsp_pc_last", fRspPc, 32'h308);
    step();
    chk("pp_drained", fPend, 0);

    // Protocol error
    doReset();
    cmdValid = 1'b1;
    cmdPc    = 32'h100;
    settle();
    chk("perr_stalled", fReady, 0);
    step();
    cmdPc = 32'h104;
    settle();
    chk("perr_not_yet", fErr, 0);
    step();
    chk("perr_set", fErr, 1);
    cmdValid     = 1'b0;
    randCmdReady = 1'b1;
    step();
    cmdValid = 1'b1;
    cmdPc    = 32'h108;
    step();
    cmdValid = 1'b0;
    step();
    chk("perr_sticky", fErr, 1);
    resetn = 1'b0;
    settle();
    chk("perr_cleared_by_reset", fErr, 0);
    chk("perr_reset_pending", fPend, 0);
    step();
    resetn = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/vex_ibus_responder.md
Name: vex_ibus_responder

Overview:
- Bounded-latency instruction-bus responder for the VexRiscv formal and simulation harness. Sits directly downstream of the core's iBus.
- Accepts fetch commands into an in-order pending FIFO and returns one response per accepted command, using externally supplied random stall and instruction inputs.
- Fairness counters cap every stall, and a sticky protocol checker flags unstable commands.

Parameters:
- DEPTH, 4: maximum outstanding commands (FIFO entries); power of two, at least 2.
- MAX_STALL, 3: maximum consecutive stall cycles on the cmd or rsp channel when FAIR=1.
- FAIR, 1: 1 enables forced ready/valid at MAX_STALL; 0 passes the random inputs through unbounded.

Ports:
- clock  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  fetch request from the core.
- cmd_pc  in  32  fetch address.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- rsp_valid  out  1  response strobe; one per accepted command, in order.
- rsp_inst  out  32  instruction word; equals rand_inst.
- rsp_pc  out  32  pc of the command being answered (head of FIFO).
- rand_cmd_ready  in  1  free random input for cmd stalling.
- rand_rsp_valid  in  1  free random input for response timing.
- rand_inst  in  32  free random instruction data.
- pending  out  $clog2(DEPTH+1)  outstanding command count.
- protocol_err  out  1  sticky flag; cmd dropped or pc changed while stalled.

Behaviour:
- Reset (resetn low, asynchronous): FIFO read/write pointers, pending, both stall counters, the previous-stall register and protocol_err all clear to 0.
- Because pending=0 and all counters are 0 during reset, cmd_ready=rand_cmd_ready (or 1 at MAX_STALL, which cannot occur) and rsp_valid=0.
- Reset mid-operation discards all outstanding entries; no response is ever issued for them.
- full = (pending==DEPTH); empty = (pending==0). Both derive from registered state only.
- cmd_ready = !full && (rand_cmd_ready || (FAIR && cmd_stall==MAX_STALL)). Combinational.
- rsp_valid = !empty && (rand_rsp_valid || (FAIR && rsp_stall==MAX_STALL)). Combinational.
- Minimum latency is 1 cycle: a command accepted in cycle N can be answered no earlier than cycle N+1.
- Push: on cmd_valid && cmd_ready, write cmd_pc at wr_ptr and increment wr_ptr modulo DEPTH.
- Pop: on rsp_valid, increment rd_ptr modulo DEPTH.
- pending update is +push -pop. Simultaneous push and pop leaves pending unchanged.
- Push is impossible when full. Pop is impossible when empty.
- Pointers are log2(DEPTH) bits and wrap naturally.
- rsp_pc = fifo[rd_ptr], valid whenever rsp_valid. rsp_inst = rand_inst, combinational.
- cmd_stall: increments, saturating at MAX_STALL, on cmd_valid && !cmd_ready; clears to 0 otherwise.
- rsp_stall: increments, saturating at MAX_STALL, on !empty && !rsp_valid; clears to 0 on rsp_valid or empty.
- Counter width is $clog2(MAX_STALL+1).
- With FAIR=1, no channel stalls more than MAX_STALL consecutive cycles.
- With FAIR=1, a full FIFO always drains because rsp_valid is forced, so cmd_ready is never held low for longer than MAX_STALL+1 cycles.
- Protocol check: register stalled_q = cmd_valid && !cmd_ready and pc_q = cmd_pc every cycle.
- If stalled_q and the current cycle has (!cmd_valid || cmd_pc != pc_q), set protocol_err. It stays set until reset.
- All state updates occur on the rising clock edge; outputs carry no extra registering beyond the state listed above.

Test Plan:
- Reset then idle: resetn low for 2 cycles with cmd_valid=0 -> pending=0, rsp_valid=0, protocol_err=0. cmd_ready follows rand_cmd_ready.
- Single fetch: cmd_valid=1, cmd_pc=0x80000000, rand_cmd_ready=1 for 1 cycle, then rand_rsp_valid=1, rand_inst=0x00000013 -> rsp_valid asserts next cycle with rsp_pc=0x80000000 and rsp_inst=0x00000013. pending goes 1 then 0.
- Fill and wrap: 6 back-to-back fetches to pcs 0x0, 0x4, ... 0x14 with rand_rsp_valid=0, FAIR=0 -> cmd_ready drops when pending=4. Responses then return 0x0, 0x4, 0x8, 0xC in order. Remaining pcs are accepted afterward with pointer wrap, and rsp_pc stays in order.
- Fairness: FAIR=1, MAX_STALL=3, rand_cmd_ready=0, rand_rsp_valid=0, cmd_valid held -> cmd_ready forced high on the 4th cycle. After acceptance, rsp_valid is forced on the 4th cycle following.
- Simultaneous push/pop: pending=2, cmd accepted and rsp_valid in the same cycle -> pending stays 2 and rsp_pc advances to the next entry.
- Protocol error: cmd stalled one cycle with pc=0x100, next cycle pc=0x104 -> protocol_err=1 from the next edge, held through further traffic, cleared only by resetn low.
